enc_speed_ctrl: RTL

Setpoint controller that sits downstream of the quadrature decoder (enc_quad). It turns step_p/dir pulses and the encoder pushbutton into a saturated speed setpoint, using fine/coarse modes and rotation-rate acceleration. New setpoints are handed to the motor/PWM stage through a valid/ready handshake that coalesces updates while the stage is busy.

---
 rtl/enc_ctrl_pkg.sv | 32 +++
 rtl/enc_btn_press.sv | 70 +++++++
 rtl/enc_speed_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/enc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_ctrl_pkg
// Brief    : Shared types for the encoder speed-setpoint controller.
// Revision : 1.0
// ============================================================================
package enc_ctrl_pkg;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_HELD = 2'd1,
        B_LONG = 2'd2
    } btn_state_e;

    typedef enum logic {
        HS_IDLE  = 1'b0,
        HS_OFFER = 1'b1
    } hs_state_e;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_SHORT = 2'd1,
        EV_LONG  = 2'd2
    } btn_evt_e;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_btn_press.sv
`default_nettype none
// ============================================================================
// Module   : enc_btn_press
// Brief    : Pushbutton short/long press classifier with one-cycle event pulses.
// Revision : 1.0
// ============================================================================
module enc_btn_press
    import enc_ctrl_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_short_p,
    output logic o_long_p
);

    localparam int               c_HW   = cnt_width(LONG_PRESS_CYC);
    localparam logic [c_HW-1:0]  c_LAST = c_HW'(LONG_PRESS_CYC - 1);

    btn_state_e      r_state;
    btn_state_e      w_next;
    btn_evt_e        w_evt;
    logic [c_HW-1:0] r_cnt;

    // Counter is held at zero outside B_HELD, so entering B_HELD starts from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= B_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == B_HELD)
                r_cnt <= r_cnt + c_HW'(1);
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        w_evt  = EV_NONE;
        case (r_state)
            B_IDLE: begin
                if (i_btn)
                    w_next = B_HELD;
            end
            B_HELD: begin
                if (!i_btn) begin
                    w_evt  = EV_SHORT;
                    w_next = B_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_evt  = EV_LONG;
                    w_next = B_LONG;
                end
            end
            B_LONG: begin
                if (!i_btn)
                    w_next = B_IDLE;
            end
            default: w_next = B_IDLE;
        endcase
    end

    assign o_short_p = (w_evt == EV_SHORT);
    assign o_long_p  = (w_evt == EV_LONG);

endmodule
`default_nettype wire

// File: rtl/enc_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enc_speed_ctrl
// Brief    : Saturating speed setpoint from encoder steps, with coalescing
//            valid/ready update handshake.
// Revision : 1.0
// ============================================================================
module enc_speed_ctrl
    import enc_ctrl_pkg::*;
#(
    parameter int W              = 16,
    parameter int SP_MIN         = 0,
    parameter int SP_MAX         = 1000,
    parameter int SP_DEFAULT     = 0,
    parameter int STEP_FINE      = 1,
    parameter int STEP_COARSE    = 10,
    parameter int FAST_WIN_CYC   = 2_000_000,
    parameter int LONG_PRESS_CYC = 100_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step_p,
    input  logic         dir,
    input  logic         btn,
    output logic [W-1:0] setpoint,
    output logic         upd_valid,
    input  logic         upd_ready,
    output logic         coarse,
    output logic         at_limit
);

    localparam int                c_GW      = cnt_width(FAST_WIN_CYC);
    localparam logic [c_GW-1:0]   c_GAP_SAT = c_GW'(FAST_WIN_CYC);
    localparam logic [W-1:0]      c_MIN     = W'(SP_MIN);
    localparam logic [W-1:0]      c_MAX     = W'(SP_MAX);
    localparam logic [W-1:0]      c_DEF     = W'(SP_DEFAULT);
    localparam logic signed [W+1:0] c_MIN_S = (W+2)'(SP_MIN);
    localparam logic signed [W+1:0] c_MAX_S = (W+2)'(SP_MAX);
    localparam logic signed [W+1:0] c_FINE  = (W+2)'(STEP_FINE);
    localparam logic signed [W+1:0] c_COARSE = (W+2)'(STEP_COARSE);
    localparam logic              c_DEF_LIM = (SP_DEFAULT == SP_MIN) || (SP_DEFAULT == SP_MAX);

    logic                 w_short_p;
    logic                 w_long_p;
    logic [c_GW-1:0]      r_gap;
    logic [W-1:0]         r_sp;
    logic [W-1:0]         r_setpoint;
    logic                 r_coarse;
    logic                 r_at_limit;
    logic                 r_init_pend;
    hs_state_e            r_hs;
    hs_state_e            w_hs_next;
    logic                 w_load;
    logic                 w_valid;
    logic signed [W+1:0]  w_base;
    logic signed [W+1:0]  w_inc;
    logic signed [W+1:0]  w_cur;
    logic signed [W+1:0]  w_sum;
    logic [W-1:0]         w_sp_step;

    enc_btn_press #(
        .LONG_PRESS_CYC (LONG_PRESS_CYC)
    ) u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_btn     (btn),
        .o_short_p (w_short_p),
        .o_long_p  (w_long_p)
    );

    // Two extra sign/headroom bits make under- and overflow visible before clamping.
    always_comb begin
        w_base = r_coarse ? c_COARSE : c_FINE;
        w_inc  = (r_gap < c_GAP_SAT) ? (w_base <<< 1) : w_base;
        w_cur  = $signed({2'b00, r_sp});
        w_sum  = dir ? (w_cur + w_inc) : (w_cur - w_inc);
        if (w_sum < c_MIN_S)
            w_sp_step = c_MIN;
        else if (w_sum > c_MAX_S)
            w_sp_step = c_MAX;
        else
            w_sp_step = w_sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap      <= c_GAP_SAT;
            r_sp       <= c_DEF;
            r_coarse   <= 1'b0;
            r_at_limit <= c_DEF_LIM;
        end else begin
            if (step_p)
                r_gap <= '0;
            else if (r_gap < c_GAP_SAT)
                r_gap <= r_gap + c_GW'(1);

            // Long press takes priority over a coincident step.
            if (w_long_p)
                r_sp <= c_DEF;
            else if (step_p)
                r_sp <= w_sp_step;

            if (w_short_p)
                r_coarse <= ~r_coarse;

            r_at_limit <= (r_sp == c_MIN) || (r_sp == c_MAX);
        end
    end

    assign w_valid = (r_hs == HS_OFFER);

    always_comb begin
        w_hs_next = r_hs;
        w_load    = 1'b0;
        if ((!w_valid || upd_ready) && ((r_sp != r_setpoint) || r_init_pend)) begin
            w_load    = 1'b1;
            w_hs_next = HS_OFFER;
        end else if (upd_ready) begin
            w_hs_next = HS_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs        <= HS_IDLE;
            r_setpoint  <= c_DEF;
            r_init_pend <= 1'b1;
        end else begin
            r_hs <= w_hs_next;
            if (w_load) begin
                r_setpoint  <= r_sp;
                r_init_pend <= 1'b0;
            end
        end
    end

    assign setpoint  = r_setpoint;
    assign upd_valid = w_valid;
    assign coarse    = r_coarse;
    assign at_limit  = r_at_limit;

endmodule
`default_nettype wire
